// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: load-use stalls, data-memory
// wait stalls and decode-resolved branch flushes, with saturating event counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [REGW-1:0] id_rn,
    input  logic [REGW-1:0] id_rm,
    input  logic            id_uses_rn,
    input  logic            id_uses_rm,
    input  logic            id_brtaken,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_regwrite,
    input  logic            ex_memtoreg,
    input  logic            mem_req,
    input  logic            mem_ready,
    input  logic            cnt_clr,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            idex_write,
    output logic            exmem_write,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic            memwb_bubble,
    output logic [1:0]      state,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10,
        ILLEGAL  = 2'b11
    } state_e;

    localparam logic [REGW-1:0] XZR     = REGW'(31);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_e          state_q, state_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

    logic rn_hit, rm_hit, lu, mw;

    // XZR reads as zero, so a load targeting it can never feed decode.
    assign rn_hit = id_uses_rn && (id_rn == ex_rd);
    assign rm_hit = id_uses_rm && (id_rm == ex_rd);
    assign lu     = ex_memtoreg && ex_regwrite && (ex_rd != XZR) && (rn_hit || rm_hit);
    assign mw     = mem_req && !mem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        state_d      = RUN;

        if (reset_n) begin
            case (state_q)
                RUN, LU_STALL, MEM_WAIT: begin
                    if (mw) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_write  = 1'b0;
                        memwb_bubble = 1'b1;
                        state_d      = MEM_WAIT;
                    end else if (lu && (state_q != LU_STALL)) begin
                        // EX holds a bubble during LU_STALL, so a stale match there is ignored.
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        state_d     = LU_STALL;
                    end else if (id_brtaken) begin
                        ifid_flush = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNTW'(1);
            end
            if (ifid_flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: REGW, default 5, register-index width.
REQ-002 Parameter: CNTW, default 16, performance-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rn  in  REGW  first source register of the instruction in decode.
REQ-006 id_rm  in  REGW  second source register (post-Reg2Loc mux) in decode.
REQ-007 id_uses_rn, id_uses_rm  in  1 each  decode instruction reads rn / rm.
REQ-008 id_brtaken  in  1  branch taken, resolved in decode (B, CBZ, B.LT).
REQ-009 ex_rd  in  REGW  destination register in execute.
REQ-010 ex_regwrite, ex_memtoreg  in  1 each  execute-stage RegWrite / MemToReg.
REQ-011 mem_req  in  1  MEM-stage instruction accesses data memory (LDUR/STUR).
REQ-012 mem_ready  in  1  data memory completes the access this cycle.
REQ-013 cnt_clr  in  1  synchronous clear of both counters.
REQ-014 pc_write, ifid_write, idex_write, exmem_write  out  1 each  stage-register enables.
REQ-015 ifid_flush  out  1  load NOP into IF/ID.
REQ-016 idex_bubble, memwb_bubble  out  1 each  insert NOP into ID/EX / MEM/WB.
REQ-017 state  out  2  FSM state: RUN=00, LU_STALL=01, MEM_WAIT=10.
REQ-018 stall_cnt, flush_cnt  out  CNTW each  stall-cycle / flush-event counters.

Function
REQ-019 Stage-control outputs are combinational from state and inputs; state and counters are registered.
REQ-020 Load-use hazard (lu) = ex_memtoreg & ex_regwrite & ex_rd!=31 & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)); register 31 (XZR) never causes a hazard.
REQ-021 Memory wait (mw) = mem_req & ~mem_ready.
REQ-022 Priority per cycle: mw > lu > id_brtaken.
REQ-023 Default (no event): all write enables 1, ifid_flush 0, bubbles 0.
REQ-024 mw active (any state): pc_write, ifid_write, idex_write, exmem_write all 0; memwb_bubble 1; ifid_flush 0; idex_bubble 0; next state MEM_WAIT.
REQ-025 MEM_WAIT: stays while mw; on mem_ready=1 outputs revert to default that cycle and next state is RUN; lu, then id_brtaken, are evaluated in that same release cycle.
REQ-026 lu in RUN, no mw: pc_write 0, ifid_write 0, idex_bubble 1, ifid_flush 0 (taken branch suppressed); next state LU_STALL.
REQ-027 LU_STALL: lu is ignored (EX holds a bubble); id_brtaken honoured; next state RUN unless mw.
REQ-028 id_brtaken with no mw and no lu: ifid_flush 1, pc_write 1, ifid_write 1; exactly one flush per taken branch.
REQ-029 Back-to-back loads feeding decode yield one bubble per load; two consecutive lu cycles in RUN are impossible by construction.
REQ-030 stall_cnt increments once per cycle in which pc_write=0; flush_cnt increments once per cycle in which ifid_flush=1.
REQ-031 Counters saturate at 2^CNTW-1; no wrap.
REQ-032 cnt_clr has priority over increment; counters read 0 next cycle.
REQ-033 state encoding 11 is illegal; if reached, next state RUN and outputs default.

Reset
REQ-034 reset_n=0 forces state RUN and both counters 0 immediately, independent of clk.
REQ-035 While reset_n=0, outputs take default values (REQ-023) regardless of inputs.
REQ-036 Reset asserted mid-MEM_WAIT or mid-LU_STALL abandons the operation; first cycle after deassertion evaluates inputs from RUN.

Verification
REQ-037 LDUR X3 in EX, ADD reading X3 in decode (ex_rd=3, id_rn=3, id_uses_rn=1) -> one cycle pc_write=0, idex_bubble=1, state 01, then RUN; stall_cnt=1.
REQ-038 Same load with ex_rd=31 -> no stall; all enables 1; stall_cnt unchanged.
REQ-039 mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 cycles all enables 0, memwb_bubble=1, state 10; release cycle defaults; stall_cnt=3.
REQ-040 lu and id_brtaken together -> cycle 1 stall, no flush; cycle 2 (LU_STALL) ifid_flush=1; flush_cnt=1.
REQ-041 stall_cnt preset near saturation by forcing 2^CNTW+5 stall cycles -> reads FFFF; cnt_clr=1 -> 0000.
REQ-042 reset_n pulsed low during MEM_WAIT (async, between edges) -> state 00 and counters 0 before next edge.
